lcd_hex_sequencer: RTL and testbench

Parametrised LCD command sequencer that turns a requested display operation into a stream of 12-bit `{cmd[3:0], payload[7:0]}` words for the LCD driver. It draws a static label banner and refreshes three hex fields: PC, select and data value. The block sits between the processor debug/status outputs and the LCD driver. It runs on a real clock, snapshots its operands, and uses a valid/ready handshake on both sides.

---
 rtl/lcd_pkg.sv | 41 ++++
 rtl/lcd_field_mux.sv | 92 +++++++++
 rtl/lcd_hex_sequencer.sv | 159 +++++++++++++++
 tb/tb_lcd_hex_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD hex sequencer: command/op codes, label ASCII,
// step-counter width, FSM state type and the nibble-to-ASCII helper.
package lcd_pkg;

    localparam logic [3:0] CMD_CLEAR = 4'h0;
    localparam logic [3:0] CMD_WRITE = 4'h1;
    localparam logic [3:0] CMD_SETCG = 4'h2;
    localparam logic [3:0] CMD_SETAD = 4'h3;
    localparam logic [3:0] CMD_WAIT  = 4'hF;

    localparam logic [1:0] OP_BANNER = 2'd0;
    localparam logic [1:0] OP_UPDATE = 2'd1;
    localparam logic [1:0] OP_CLEAR  = 2'd2;
    localparam logic [1:0] OP_RSVD   = 2'd3;

    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_P     = 8'h50;
    localparam logic [7:0] ASC_C     = 8'h43;
    localparam logic [7:0] ASC_S     = 8'h53;
    localparam logic [7:0] ASC_E_LC  = 8'h65;
    localparam logic [7:0] ASC_L_LC  = 8'h6C;
    localparam logic [7:0] ASC_V     = 8'h56;
    localparam logic [7:0] ASC_A_LC  = 8'h61;

    // Longest sequence is an UPDATE with 16-bit PC, 8-bit select, 32-bit data: 17 steps.
    localparam int SS_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BANNER,
        ST_UPDATE,
        ST_CLEAR,
        ST_FIN
    } seq_state_e;

    function automatic logic [7:0] hex2ascii(input logic [3:0] nibble);
        return (nibble <= 4'd9) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});
    endfunction

endpackage

// File: rtl/lcd_field_mux.sv
// Payload byte selection for the current sequence step: banner labels, field
// addresses and hex digits. Leading-zero blanking of data under LCD_SEQ_LZB_EN.
module lcd_field_mux
    import lcd_pkg::*;
#(
    parameter int         PC_W      = 8,
    parameter int         SEL_W     = 4,
    parameter int         DATA_W    = 32,
    parameter logic [7:0] PC_ADDR   = 8'h04,
    parameter logic [7:0] SEL_ADDR  = 8'h0D,
    parameter logic [7:0] DATA_ADDR = 8'h30
) (
    input  seq_state_e        state_i,
    input  logic [SS_W-1:0]   ss_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [7:0]        payload_o
);
    localparam int PCD       = PC_W / 4;
    localparam int SELD      = SEL_W / 4;
    localparam int DATAD     = DATA_W / 4;
    localparam int SEL_BASE  = PCD + 1;
    localparam int DATA_BASE = PCD + SELD + 2;

    int         step;
    int         idx;
    logic [3:0] nib;
`ifdef LCD_SEQ_LZB_EN
    logic [DATA_W-1:0] upper;
`endif

    always_comb begin
        step      = int'(ss_i);
        idx       = 0;
        nib       = 4'h0;
        payload_o = 8'h00;
`ifdef LCD_SEQ_LZB_EN
        upper     = '0;
`endif
        case (state_i)
            ST_BANNER: begin
                case (step)
                    2:       payload_o = ASC_P;
                    3:       payload_o = ASC_C;
                    4:       payload_o = ASC_COLON;
                    5:       payload_o = 8'h08;
                    6:       payload_o = ASC_S;
                    7:       payload_o = ASC_E_LC;
                    8:       payload_o = ASC_L_LC;
                    9:       payload_o = ASC_COLON;
                    10:      payload_o = 8'h28;
                    11:      payload_o = ASC_V;
                    12:      payload_o = ASC_A_LC;
                    13:      payload_o = ASC_L_LC;
                    14:      payload_o = ASC_COLON;
                    default: payload_o = 8'h00;
                endcase
            end
            ST_UPDATE: begin
                // Digits go out most significant nibble first, so idx counts down.
                if (step == 0) begin
                    payload_o = PC_ADDR;
                end else if (step <= PCD) begin
                    idx       = PCD - step;
                    nib       = 4'(pc_i >> (4 * idx));
                    payload_o = hex2ascii(nib);
                end else if (step == SEL_BASE) begin
                    payload_o = SEL_ADDR;
                end else if (step < DATA_BASE) begin
                    idx       = SELD - (step - SEL_BASE);
                    nib       = 4'(sel_i >> (4 * idx));
                    payload_o = hex2ascii(nib);
                end else if (step == DATA_BASE) begin
                    payload_o = DATA_ADDR;
                end else begin
                    idx       = DATAD - (step - DATA_BASE);
                    nib       = 4'(data_i >> (4 * idx));
                    payload_o = hex2ascii(nib);
`ifdef LCD_SEQ_LZB_EN
                    upper = data_i >> (4 * idx);
                    if ((upper == '0) && (idx != 0)) begin
                        payload_o = ASC_SPACE;
                    end
`endif
                end
            end
            default: payload_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/lcd_hex_sequencer.sv
// LCD command sequencer: snapshots operands on accept and streams BANNER/UPDATE/CLEAR
// command words over a valid/ready link. Define LCD_SEQ_LZB_EN for data-field blanking.
module lcd_hex_sequencer
    import lcd_pkg::*;
#(
    parameter int         PC_W      = 8,
    parameter int         SEL_W     = 4,
    parameter int         DATA_W    = 32,
    parameter logic [7:0] PC_ADDR   = 8'h04,
    parameter logic [7:0] SEL_ADDR  = 8'h0D,
    parameter logic [7:0] DATA_ADDR = 8'h30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic [1:0]        op,
    output logic              op_ready,
    input  logic [PC_W-1:0]   pc,
    input  logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [11:0]       cmd,
    output logic              done
);
    localparam int              UPD_LEN     = 3 + PC_W / 4 + SEL_W / 4 + DATA_W / 4;
    localparam logic [SS_W-1:0] LAST_BANNER = SS_W'(14);
    localparam logic [SS_W-1:0] LAST_UPDATE = SS_W'(UPD_LEN - 1);
    localparam logic [SS_W-1:0] SS_SEL_AD   = SS_W'(PC_W / 4 + 1);
    localparam logic [SS_W-1:0] SS_DATA_AD  = SS_W'(PC_W / 4 + SEL_W / 4 + 2);

    seq_state_e        state_q;
    logic [SS_W-1:0]   ss_q;
    logic [PC_W-1:0]   pc_q;
    logic [SEL_W-1:0]  sel_q;
    logic [DATA_W-1:0] data_q;
    logic              op_ready_q;
    logic              cmd_valid_q;
    logic              done_q;

    logic [SS_W-1:0]   last_ss_d;
    logic [3:0]        cmd_code_d;
    logic [7:0]        payload_d;

    lcd_field_mux #(
        .PC_W      (PC_W),
        .SEL_W     (SEL_W),
        .DATA_W    (DATA_W),
        .PC_ADDR   (PC_ADDR),
        .SEL_ADDR  (SEL_ADDR),
        .DATA_ADDR (DATA_ADDR)
    ) u_field_mux (
        .state_i   (state_q),
        .ss_i      (ss_q),
        .pc_i      (pc_q),
        .sel_i     (sel_q),
        .data_i    (data_q),
        .payload_o (payload_d)
    );

    always_comb begin
        last_ss_d  = '0;
        cmd_code_d = CMD_WAIT;
        case (state_q)
            ST_BANNER: begin
                last_ss_d = LAST_BANNER;
                if (ss_q == '0)
                    cmd_code_d = CMD_CLEAR;
                else if ((ss_q == SS_W'(1)) || (ss_q == SS_W'(5)) || (ss_q == SS_W'(10)))
                    cmd_code_d = CMD_SETAD;
                else
                    cmd_code_d = CMD_WRITE;
            end
            ST_UPDATE: begin
                last_ss_d = LAST_UPDATE;
                if ((ss_q == '0) || (ss_q == SS_SEL_AD) || (ss_q == SS_DATA_AD))
                    cmd_code_d = CMD_SETAD;
                else
                    cmd_code_d = CMD_WRITE;
            end
            ST_CLEAR: begin
                last_ss_d  = '0;
                cmd_code_d = CMD_CLEAR;
            end
            default: begin
                last_ss_d  = '0;
                cmd_code_d = CMD_WAIT;
            end
        endcase
    end

    // done_q is high exactly while in FIN; op_ready_q returns with the move back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ss_q        <= '0;
            pc_q        <= '0;
            sel_q       <= '0;
            data_q      <= '0;
            op_ready_q  <= 1'b0;
            cmd_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    op_ready_q <= 1'b1;
                    if (op_valid && op_ready_q) begin
                        pc_q       <= pc;
                        sel_q      <= sel;
                        data_q     <= data;
                        ss_q       <= '0;
                        op_ready_q <= 1'b0;
                        case (op)
                            OP_BANNER: begin
                                state_q     <= ST_BANNER;
                                cmd_valid_q <= 1'b1;
                            end
                            OP_UPDATE: begin
                                state_q     <= ST_UPDATE;
                                cmd_valid_q <= 1'b1;
                            end
                            OP_CLEAR: begin
                                state_q     <= ST_CLEAR;
                                cmd_valid_q <= 1'b1;
                            end
                            OP_RSVD: begin
                                state_q <= ST_FIN;
                                done_q  <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_BANNER, ST_UPDATE, ST_CLEAR: begin
                    if (cmd_valid_q && cmd_ready) begin
                        if (ss_q == last_ss_d) begin
                            state_q     <= ST_FIN;
                            cmd_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            ss_q <= ss_q + SS_W'(1);
                        end
                    end
                end
                ST_FIN: begin
                    state_q    <= ST_IDLE;
                    op_ready_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign op_ready  = op_ready_q;
    assign cmd_valid = cmd_valid_q;
    assign done      = done_q;
    assign cmd       = cmd_valid_q ? {cmd_code_d, payload_d} : {CMD_WAIT, 8'h00};

endmodule

// File: tb/tb_lcd_hex_sequencer.sv
// Self-checking bench for lcd_hex_sequencer: queue-based model of the expected word
// stream and handshake timing, plus literal expectations for the documented sequences.
module tb_lcd_hex_sequencer;

    localparam int         PC_W      = 8;
    localparam int         SEL_W     = 4;
    localparam int         DATA_W    = 32;
    localparam logic [7:0] PC_ADDR   = 8'h04;
    localparam logic [7:0] SEL_ADDR  = 8'h0D;
    localparam logic [7:0] DATA_ADDR = 8'h30;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              op_valid;
    logic [1:0]        op;
    logic              op_ready;
    logic [PC_W-1:0]   pc;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [11:0]       cmd;
    logic              done;

    always #5 clk = ~clk;

    lcd_hex_sequencer #(
        .PC_W(PC_W), .SEL_W(SEL_W), .DATA_W(DATA_W),
        .PC_ADDR(PC_ADDR), .SEL_ADDR(SEL_ADDR), .DATA_ADDR(DATA_ADDR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .op_ready(op_ready),
        .pc(pc), .sel(sel), .data(data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .done(done)
    );

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          accCyc   = 0;
    logic [11:0] expQ[$];
    logic [11:0] wordLog[$];
    logic [11:0] want[$];
    logic        mRdy, mValid, mDone;
    logic        readyRandom, scramble;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hexChar(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h41 + {4'h0, n} - 8'd10;
    endfunction

    function automatic void pushLabel(input logic [7:0] addr, input string s);
        expQ.push_back({4'h3, addr});
        for (int i = 0; i < s.len(); i++) expQ.push_back({4'h1, 8'(s[i])});
    endfunction

    function automatic void buildSeq(input logic [1:0] o, input logic [PC_W-1:0] p,
                                     input logic [SEL_W-1:0] s, input logic [DATA_W-1:0] d);
        int msd;
        bit lzb;
        lzb = 1'b0;
`ifdef LCD_SEQ_LZB_EN
        lzb = 1'b1;
`endif
        case (o)
            2'd0: begin
                expQ.push_back(12'h000);
                pushLabel(8'h00, "PC:");
                pushLabel(8'h08, "Sel:");
                pushLabel(8'h28, "Val:");
            end
            2'd1: begin
                expQ.push_back({4'h3, PC_ADDR});
                for (int i = PC_W / 4 - 1; i >= 0; i--) expQ.push_back({4'h1, hexChar(p[4*i +: 4])});
                expQ.push_back({4'h3, SEL_ADDR});
                for (int i = SEL_W / 4 - 1; i >= 0; i--) expQ.push_back({4'h1, hexChar(s[4*i +: 4])});
                expQ.push_back({4'h3, DATA_ADDR});
                msd = 0;
                for (int i = 0; i < DATA_W / 4; i++) if (d[4*i +: 4] != 4'h0) msd = i;
                for (int i = DATA_W / 4 - 1; i >= 0; i--) begin
                    if (lzb && (i > msd)) expQ.push_back(12'h120);
                    else expQ.push_back({4'h1, hexChar(d[4*i +: 4])});
                end
            end
            2'd2: expQ.push_back(12'h000);
            default: ;
        endcase
    endfunction

    // Reference model: expected words queue, advanced by handshakes seen on the link.
    initial begin
        mRdy = 1'b0; mValid = 1'b0; mDone = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mRdy = 1'b0; mValid = 1'b0; mDone = 1'b0;
                expQ.delete();
            end else begin
                cyc++;
                if (cmd_valid && cmd_ready) wordLog.push_back(cmd);
                if (mDone) begin
                    mDone = 1'b0;
                    mRdy  = 1'b1;
                end else if (mValid) begin
                    if (cmd_ready) begin
                        void'(expQ.pop_front());
                        if (expQ.size() == 0) begin
                            mValid = 1'b0;
                            mDone  = 1'b1;
                        end
                    end
                end else if (op_valid && mRdy) begin
                    buildSeq(op, pc, sel, data);
                    mRdy = 1'b0;
                    if (expQ.size() == 0) mDone = 1'b1;
                    else mValid = 1'b1;
                end else begin
                    mRdy = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            checkOutput("op_ready", op_ready, mRdy);
            checkOutput("cmd_valid", cmd_valid, mValid);
            checkOutput("done", done, mDone);
            checkOutput("cmd", cmd, mValid ? expQ[0] : 12'hF00);
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #2;
        cmd_ready = readyRandom ? ($urandom_range(0, 9) < 6) : 1'b1;
        if (scramble && !op_valid) begin
            pc = PC_W'($urandom); sel = SEL_W'($urandom); data = DATA_W'($urandom);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] o, input logic [PC_W-1:0] p,
                                 input logic [SEL_W-1:0] s, input logic [DATA_W-1:0] d);
        int n;
        bit got;
        wordLog.delete();
        op = o; pc = p; sel = s; data = d; op_valid = 1'b1;
        got = 1'b0; n = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            got = op_ready;
            stepCycle();
            n++;
        end
        op_valid = 1'b0;
        accCyc = cyc;
        if (scramble) begin
            pc = PC_W'($urandom); sel = SEL_W'($urandom); data = DATA_W'($urandom);
        end
        checkOutput("accept_timeout", got, 1);
    endtask

    task automatic waitDone(output int delta);
        int n;
        bit seen;
        seen = 1'b0; n = 0; delta = -1;
        while (!seen && n < 500) begin
            @(negedge clk);
            if (done) begin
                seen  = 1'b1;
                delta = cyc - accCyc;
            end
            stepCycle();
            n++;
        end
        checkOutput("done_timeout", seen, 1);
    endtask

    task automatic checkWords(input string name);
        checkOutput({name, "_count"}, wordLog.size(), want.size());
        for (int i = 0; i < want.size(); i++)
            checkOutput($sformatf("%s[%0d]", name, i), (i < wordLog.size()) ? {20'h0, wordLog[i]} : 32'hDEAD, want[i]);
    endtask

    task automatic setUpdateWant(input bit zeroData);
        want = '{12'h304, 12'h133, 12'h146, 12'h30D, 12'h141, 12'h330};
        if (zeroData) begin
`ifdef LCD_SEQ_LZB_EN
            repeat (7) want.push_back(12'h120);
`else
            repeat (7) want.push_back(12'h130);
`endif
            want.push_back(12'h130);
        end else begin
`ifdef LCD_SEQ_LZB_EN
            repeat (4) want.push_back(12'h120);
`else
            repeat (4) want.push_back(12'h130);
`endif
            want.push_back(12'h131); want.push_back(12'h132);
            want.push_back(12'h141); want.push_back(12'h142);
        end
    endtask

    initial begin
        int d;
        int n;
        rst_n = 1'b0; op_valid = 1'b0; op = 2'd0; pc = '0; sel = '0; data = '0;
        cmd_ready = 1'b1; readyRandom = 1'b0; scramble = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_op_ready", op_ready, 0);
        checkOutput("rst_cmd_valid", cmd_valid, 0);
        checkOutput("rst_cmd", cmd, 12'hF00);
        checkOutput("rst_done", done, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("release_op_ready_before_edge", op_ready, 0);
        stepCycle();
        @(negedge clk);
        checkOutput("release_op_ready_after_edge", op_ready, 1);
        stepCycle();

        applyStimulus(2'd0, 8'h00, 4'h0, 32'h0);
        waitDone(d);
        checkOutput("banner_done_delta", d, 15);
        want = '{12'h000, 12'h300, 12'h150, 12'h143, 12'h13A, 12'h308, 12'h153, 12'h165,
                 12'h16C, 12'h13A, 12'h328, 12'h156, 12'h161, 12'h16C, 12'h13A};
        checkWords("banner");

        applyStimulus(2'd1, 8'h3F, 4'hA, 32'h0000_12AB);
        waitDone(d);
        checkOutput("update_done_delta", d, 14);
        setUpdateWant(1'b0);
        checkWords("update");

        applyStimulus(2'd1, 8'h3F, 4'hA, 32'h0);
        waitDone(d);
        setUpdateWant(1'b1);
        checkWords("update_zero");

        applyStimulus(2'd2, 8'h12, 4'h3, 32'h4);
        waitDone(d);
        checkOutput("clear_done_delta", d, 1);
        want = '{12'h000};
        checkWords("clear");

        applyStimulus(2'd3, 8'h55, 4'h5, 32'h5);
        waitDone(d);
        checkOutput("rsvd_done_delta", d, 0);
        checkOutput("rsvd_words", wordLog.size(), 0);

        readyRandom = 1'b1; scramble = 1'b1;
        applyStimulus(2'd1, 8'h3F, 4'hA, 32'h0000_12AB);
        waitDone(d);
        setUpdateWant(1'b0);
        checkWords("update_bp");
        readyRandom = 1'b0; scramble = 1'b0;

        applyStimulus(2'd0, 8'h00, 4'h0, 32'h0);
        op = 2'd1; pc = 8'h3F; sel = 4'hA; data = 32'h0000_12AB; op_valid = 1'b1;
        waitDone(d);
        checkOutput("hold_banner_delta", d, 15);
        applyStimulus(2'd1, 8'h3F, 4'hA, 32'h0000_12AB);
        waitDone(d);
        setUpdateWant(1'b0);
        checkWords("update_held");

        applyStimulus(2'd0, 8'h00, 4'h0, 32'h0);
        n = 0;
        while (wordLog.size() < 5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reset_wait_words", wordLog.size(), 5);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_cmd_valid", cmd_valid, 0);
        checkOutput("midrst_cmd", cmd, 12'hF00);
        checkOutput("midrst_op_ready", op_ready, 0);
        stepCycle(); stepCycle();
        rst_n = 1'b1;
        applyStimulus(2'd1, 8'h3F, 4'hA, 32'h0000_12AB);
        waitDone(d);
        setUpdateWant(1'b0);
        checkWords("update_after_rst");

        readyRandom = 1'b1; scramble = 1'b1;
        for (int k = 0; k < 30; k++) begin
            applyStimulus(2'($urandom_range(0, 3)), PC_W'($urandom), SEL_W'($urandom),
                          (k % 4 == 0) ? DATA_W'($urandom_range(0, 255)) : DATA_W'($urandom));
            waitDone(d);
        end
        readyRandom = 1'b0; scramble = 1'b0;
        stepCycle(); stepCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
